supersaw_mux: RTL and testbench

Parametrised, time-multiplexed supersaw oscillator. It runs VOICES detuned phase accumulators through a single adder and sums them into one audio sample per sample tick. Detune depth is adjustable at run time, and a hard-sync input realigns all voice phases. It sits in the audio path between the pitch/control logic and the DAC/mixer and replaces the fixed eight-ramp free-running oscillator.

---
 rtl/supersaw_pkg.sv | 27 ++
 rtl/supersaw_voice_inc.sv | 29 ++
 rtl/supersaw_mux.sv | 115 +++++++++++
 tb/tb_supersaw_mux.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/supersaw_pkg.sv
// Shared types, constants and helpers for the time-multiplexed supersaw oscillator.
package supersaw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DETUNE_N = 32;

  // Entry 0 is zero so voice 0 stays on the undetuned reference pitch.
  localparam logic [15:0] DETUNE [DETUNE_N] = '{
    16'd0,     16'd1333,  16'd2777,  16'd3077,  16'd4577,  16'd5336,  16'd6789,  16'd7612,
    16'd8111,  16'd9043,  16'd10267, 16'd11131, 16'd12409, 16'd13177, 16'd14503, 16'd15263,
    16'd16021, 16'd17389, 16'd18233, 16'd19477, 16'd20123, 16'd21611, 16'd22307, 16'd23869,
    16'd24413, 16'd25759, 16'd26597, 16'd27883, 16'd28429, 16'd29947, 16'd30713, 16'd31991
  };

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/supersaw_voice_inc.sv
// Combinational per-voice phase step: detuned increment added to the selected base phase.
module supersaw_voice_inc
  import supersaw_pkg::*;
#(
  parameter int ACC_W       = 32,
  parameter int PITCH_W     = 16,
  parameter int PITCH_SHIFT = 8,
  parameter int IDX_W       = 3
) (
  input  logic [ACC_W-1:0]   base,
  input  logic [PITCH_W-1:0] pitch,
  input  logic [7:0]         spread,
  input  logic [IDX_W-1:0]   index,
  output logic [ACC_W-1:0]   new_phase
);

  logic [4:0]       idx5;
  logic [15:0]      detune_inc;
  logic [ACC_W-1:0] inc;

  assign idx5 = 5'(index);

  // spread * DETUNE fits in 24 bits; the >> 8 scales full spread to roughly DETUNE itself.
  assign detune_inc = 16'(({16'd0, spread} * {8'd0, DETUNE[idx5]}) >> 8);

  assign inc       = (ACC_W'(pitch) << PITCH_SHIFT) + ACC_W'(detune_inc);
  assign new_phase = base + inc;

endmodule

// File: rtl/supersaw_mux.sv
// Supersaw oscillator: VOICES phase accumulators share one adder, summed into one sample per tick.
module supersaw_mux
  import supersaw_pkg::*;
#(
  parameter int VOICES      = 8,
  parameter int ACC_W       = 32,
  parameter int PITCH_W     = 16,
  parameter int PITCH_SHIFT = 8,
  parameter int SAMP_W      = 13,
  parameter int OUT_W       = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               sample_tick,
  input  logic [PITCH_W-1:0] pitch,
  input  logic [7:0]         spread,
  input  logic               sync,
  output logic [OUT_W-1:0]   audio_out,
  output logic               audio_valid,
  output logic               overrun,
  output state_t             state_dbg
);

  localparam int IDX_W   = clog2(VOICES);
  localparam int SUM_W   = SAMP_W + IDX_W;
  localparam int STAG_SH = ACC_W - IDX_W;

  // Handshake: sample_tick is a request with no ready; a tick outside IDLE is dropped and
  // flagged on overrun one cycle later. audio_valid is a one-cycle strobe with no backpressure.

  state_t               state, state_next;
  logic [ACC_W-1:0]     phase_q [VOICES];
  logic [IDX_W-1:0]     idx_q;
  logic [SUM_W-1:0]     acc_q;
  logic [PITCH_W-1:0]   pitch_q;
  logic [7:0]           spread_q;
  logic                 sync_q;

  logic [ACC_W-1:0]     stagger_cur;
  logic [ACC_W-1:0]     base;
  logic [ACC_W-1:0]     new_phase;
  logic [SUM_W-1:0]     acc_sum;
  logic                 last;

  assign stagger_cur = ACC_W'(idx_q) << STAG_SH;
  assign base        = sync_q ? stagger_cur : phase_q[idx_q];
  assign acc_sum     = acc_q + SUM_W'(new_phase[ACC_W-1 -: SAMP_W]);
  assign last        = (idx_q == IDX_W'(VOICES - 1));
  assign state_dbg   = state;

  supersaw_voice_inc #(
    .ACC_W       (ACC_W),
    .PITCH_W     (PITCH_W),
    .PITCH_SHIFT (PITCH_SHIFT),
    .IDX_W       (IDX_W)
  ) u_voice_inc (
    .base      (base),
    .pitch     (pitch_q),
    .spread    (spread_q),
    .index     (idx_q),
    .new_phase (new_phase)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (sample_tick) state_next = ST_RUN;
      ST_RUN:  if (last)        state_next = ST_DONE;
      ST_DONE:                  state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      pitch_q     <= '0;
      spread_q    <= '0;
      sync_q      <= 1'b0;
      audio_out   <= '0;
      audio_valid <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < VOICES; i++) phase_q[i] <= ACC_W'(i) << STAG_SH;
    end else begin
      state       <= state_next;
      audio_valid <= 1'b0;
      overrun     <= sample_tick && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (sample_tick) begin
            pitch_q  <= pitch;
            spread_q <= spread;
            sync_q   <= sync;
            idx_q    <= '0;
            acc_q    <= '0;
          end
        end
        ST_RUN: begin
          phase_q[idx_q] <= new_phase;
          acc_q          <= acc_sum;
          idx_q          <= idx_q + IDX_W'(1);
          // Output is loaded on entry to DONE so it is visible during the DONE cycle itself.
          if (last) begin
            audio_out   <= acc_sum[SUM_W-1 -: OUT_W];
            audio_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_supersaw_mux.sv
// Directed bench for supersaw_mux: frame timing, pitch/detune sums, overrun, sync and reset abort.
module tb_supersaw_mux;
  import supersaw_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sample_tick;
  logic [15:0] pitch;
  logic [7:0]  spread;
  logic        sync;
  logic [15:0] audio_out;
  logic        audio_valid;
  logic        overrun;
  state_t      state_dbg;

  int checks   = 0;
  int failures = 0;
  int ovr_cnt  = 0;

  logic [15:0] exp_q[$];
  logic [31:0] mph [8];

  localparam logic [31:0] DET [8] = '{32'd0, 32'd1333, 32'd2777, 32'd3077,
                                      32'd4577, 32'd5336, 32'd6789, 32'd7612};

  always #5 clk = ~clk;

  supersaw_mux dut (
    .clk         (clk),
    .resetn      (resetn),
    .sample_tick (sample_tick),
    .pitch       (pitch),
    .spread      (spread),
    .sync        (sync),
    .audio_out   (audio_out),
    .audio_valid (audio_valid),
    .overrun     (overrun),
    .state_dbg   (state_dbg)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    sample_tick = 1'b0;
    pitch       = '0;
    spread      = '0;
    sync        = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Caller is at a negedge; the tick is sampled on the following posedge.
  task automatic run_frame(input int spacing, output logic [15:0] val, output int lat,
                           output int nval);
    val  = '0;
    lat  = -1;
    nval = 0;
    sample_tick = 1'b1;
    for (int k = 1; k <= spacing; k++) begin
      @(negedge clk);
      if (audio_valid) begin
        nval++;
        if (lat < 0) begin
          lat = k;
          val = audio_out;
        end
      end
      if (overrun) ovr_cnt++;
      if (k == 1) sample_tick = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mph[i] = 32'(i) << 29;
  endtask

  task automatic model_step(input logic [15:0] p, input logic [7:0] s, input logic syn,
                            output logic [15:0] sum);
    logic [31:0] b, inc;
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      b      = syn ? (32'(i) << 29) : mph[i];
      inc    = ({16'd0, p} << 8) + ((32'(s) * DET[i]) >> 8);
      mph[i] = b + inc;
      sum    = sum + 16'(mph[i][31:19]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v, e;
    int l, n, nv, vk, no, ok;

    // Scenario 1: reset values and a single idle-pitch frame
    do_reset();
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    check("rst_out", audio_out, 0);
    check("rst_valid", audio_valid, 0);
    check("rst_overrun", overrun, 0);
    run_frame(12, v, l, n);
    check("s1_lat", l, 9);
    check("s1_out", v, 28672);
    check("s1_nvalid", n, 1);

    // Scenario 2: pitch 0x0100 adds 1/8 LSB per frame to every voice
    do_reset();
    pitch = 16'h0100;
    for (int f = 1; f <= 8; f++) begin
      run_frame(12, v, l, n);
      check("s2_lat", l, 9);
      check("s2_out", v, (f < 8) ? 28672 : 28680);
    end

    // Scenario 3: max pitch and spread at minimum tick spacing against the model
    do_reset();
    pitch  = 16'hFFFF;
    spread = 8'd255;
    model_reset();
    for (int f = 1; f <= 1000; f++) begin
      model_step(pitch, spread, 1'b0, e);
      exp_q.push_back(e);
      run_frame(10, v, l, n);
      check("s3_lat", l, 9);
      e = exp_q.pop_front();
      check("s3_out", v, e);
      if (f == 100) begin
        for (int i = 0; i < 8; i++) begin
          check("s3_phase", dut.phase_q[i], mph[i]);
          for (int j = i + 1; j < 8; j++)
            check("s3_distinct", (dut.phase_q[i] != dut.phase_q[j]), 1);
        end
      end
    end

    // Scenario 5: sync from arbitrary phases, held high, then released
    sync   = 1'b1;
    pitch  = '0;
    spread = '0;
    model_step(pitch, spread, 1'b1, e);
    run_frame(12, v, l, n);
    check("s5_sync_zero", v, 28672);
    pitch  = 16'h1234;
    spread = 8'd100;
    for (int f = 0; f < 2; f++) begin
      model_step(pitch, spread, 1'b1, e);
      run_frame(12, v, l, n);
      check("s5_sync_held", v, e);
    end
    sync = 1'b0;
    model_step(pitch, spread, 1'b0, e);
    run_frame(12, v, l, n);
    check("s5_sync_rel", v, e);

    // Scenario 4: tick during RUN is dropped and flagged; pitch change mid-frame ignored
    do_reset();
    sample_tick = 1'b1;
    nv = 0; vk = -1; no = 0; ok = -1; v = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (audio_valid) begin
        nv++;
        if (vk < 0) begin
          vk = k;
          v  = audio_out;
        end
      end
      if (overrun) begin
        no++;
        if (ok < 0) ok = k;
      end
      if (k == 1) sample_tick = 1'b0;
      if (k == 3) begin
        sample_tick = 1'b1;
        pitch       = 16'hFFFF;
      end
      if (k == 4) sample_tick = 1'b0;
    end
    check("s4_ovr_count", no, 1);
    check("s4_ovr_when", ok, 4);
    check("s4_lat", vk, 9);
    check("s4_out", v, 28672);
    check("s4_nvalid", nv, 1);
    check("s4_idle", 64'(state_dbg), 64'(ST_IDLE));
    pitch = '0;

    // Scenario 6: reset mid-frame aborts and restores phases
    do_reset();
    run_frame(12, v, l, n);
    check("s6_pre_out", v, 28672);
    pitch       = 16'hFFFF;
    sample_tick = 1'b1;
    nv = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (audio_valid) nv++;
      if (k == 1) sample_tick = 1'b0;
      if (k == 4) resetn = 1'b0;
    end
    check("s6_nvalid", nv, 0);
    check("s6_out", audio_out, 0);
    check("s6_idle", 64'(state_dbg), 64'(ST_IDLE));
    check("s6_overrun", overrun, 0);
    resetn = 1'b1;
    pitch  = '0;
    @(negedge clk);
    run_frame(12, v, l, n);
    check("s6_post_lat", l, 9);
    check("s6_post_out", v, 28672);

    check("no_overrun", ovr_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
